// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: predicts the next PC in IF,
// resolves jumps in ID and conditional branches in EX, and produces the redirect PC.
module branch_predictor #(
    parameter int WORD_SIZE  = 16,
    parameter int INDEX_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] pc_IF,
    output logic [WORD_SIZE-1:0] next_pc_pred,
    output logic                 pred_taken,
    input  logic                 jump_valid_ID,
    input  logic [WORD_SIZE-1:0] pc_ID,
    input  logic [WORD_SIZE-1:0] jump_target_ID,
    input  logic                 pred_taken_ID,
    input  logic [WORD_SIZE-1:0] pred_target_ID,
    input  logic                 branch_valid_EX,
    input  logic [WORD_SIZE-1:0] pc_EX,
    input  logic                 branch_taken_EX,
    input  logic [WORD_SIZE-1:0] branch_target_EX,
    input  logic                 pred_taken_EX,
    input  logic [WORD_SIZE-1:0] pred_target_EX,
    output logic                 jump_miss,
    output logic                 i_branch_miss,
    output logic [WORD_SIZE-1:0] correct_pc,
    output logic [15:0]          miss_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = WORD_SIZE - INDEX_BITS;
    localparam logic [WORD_SIZE-1:0] ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};

    logic                 r_valid  [ENTRIES];
    logic [TAG_W-1:0]     r_tag    [ENTRIES];
    logic [WORD_SIZE-1:0] r_target [ENTRIES];
    logic [1:0]           r_cnt    [ENTRIES];
    logic [15:0]          r_miss_count;

    logic [INDEX_BITS-1:0] w_if_idx, w_id_idx, w_ex_idx;
    logic                  w_if_hit, w_ex_hit;
    logic                  w_br_miss, w_jmp_miss_raw;
    logic                  w_br_upd, w_jmp_upd;
    logic [1:0]            w_ex_cnt_next;

    assign w_if_idx = pc_IF[INDEX_BITS-1:0];
    assign w_id_idx = pc_ID[INDEX_BITS-1:0];
    assign w_ex_idx = pc_EX[INDEX_BITS-1:0];

    assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == pc_IF[WORD_SIZE-1:INDEX_BITS]);
    assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == pc_EX[WORD_SIZE-1:INDEX_BITS]);

    assign pred_taken   = w_if_hit && r_cnt[w_if_idx][1];
    assign next_pc_pred = pred_taken ? r_target[w_if_idx] : pc_IF + ONE;

    assign w_br_miss = branch_valid_EX &&
                       ((branch_taken_EX != pred_taken_EX) ||
                        (branch_taken_EX && (branch_target_EX != pred_target_EX)));
    assign w_jmp_miss_raw = jump_valid_ID &&
                            (!pred_taken_ID || (pred_target_ID != jump_target_ID));

    // The EX branch is older, so its miss hides any ID jump miss.
    assign i_branch_miss = w_br_miss;
    assign jump_miss     = w_jmp_miss_raw && !w_br_miss;
    assign correct_pc    = w_br_miss ? (branch_taken_EX ? branch_target_EX : pc_EX + ONE)
                                     : jump_target_ID;

    assign w_br_upd  = branch_valid_EX && (w_ex_hit || branch_taken_EX);
    assign w_jmp_upd = jump_valid_ID && !w_br_miss && !(w_br_upd && (w_id_idx == w_ex_idx));

    always_comb begin
        w_ex_cnt_next = r_cnt[w_ex_idx];
        if (branch_taken_EX) begin
            if (r_cnt[w_ex_idx] != 2'b11) w_ex_cnt_next = r_cnt[w_ex_idx] + 2'b01;
        end else begin
            if (r_cnt[w_ex_idx] != 2'b00) w_ex_cnt_next = r_cnt[w_ex_idx] - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_cnt[i]    <= 2'b01;
            end
            r_miss_count <= '0;
        end else begin
            if (w_jmp_upd) begin
                r_valid[w_id_idx]  <= 1'b1;
                r_tag[w_id_idx]    <= pc_ID[WORD_SIZE-1:INDEX_BITS];
                r_target[w_id_idx] <= jump_target_ID;
                r_cnt[w_id_idx]    <= 2'b11;
            end
            if (w_br_upd) begin
                if (w_ex_hit) begin
                    r_cnt[w_ex_idx] <= w_ex_cnt_next;
                end else begin
                    r_valid[w_ex_idx] <= 1'b1;
                    r_tag[w_ex_idx]   <= pc_EX[WORD_SIZE-1:INDEX_BITS];
                    r_cnt[w_ex_idx]   <= 2'b10;
                end
                if (branch_taken_EX) r_target[w_ex_idx] <= branch_target_EX;
            end
            if ((jump_miss || i_branch_miss) && (r_miss_count != 16'hFFFF))
                r_miss_count <= r_miss_count + 16'd1;
        end
    end

    assign miss_count = r_miss_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor: each record is one cycle of
// stimulus plus the hand-computed outputs expected before the following clock edge.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc_IF, next_pc_pred;
    logic        pred_taken;
    logic        jump_valid_ID, pred_taken_ID;
    logic [15:0] pc_ID, jump_target_ID, pred_target_ID;
    logic        branch_valid_EX, branch_taken_EX, pred_taken_EX;
    logic [15:0] pc_EX, branch_target_EX, pred_target_EX;
    logic        jump_miss, i_branch_miss;
    logic [15:0] correct_pc, miss_count;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    branch_predictor #(.WORD_SIZE(16), .INDEX_BITS(4)) dut (
        .clk(clk), .reset(reset), .pc_IF(pc_IF), .next_pc_pred(next_pc_pred),
        .pred_taken(pred_taken), .jump_valid_ID(jump_valid_ID), .pc_ID(pc_ID),
        .jump_target_ID(jump_target_ID), .pred_taken_ID(pred_taken_ID),
        .pred_target_ID(pred_target_ID), .branch_valid_EX(branch_valid_EX),
        .pc_EX(pc_EX), .branch_taken_EX(branch_taken_EX),
        .branch_target_EX(branch_target_EX), .pred_taken_EX(pred_taken_EX),
        .pred_target_EX(pred_target_EX), .jump_miss(jump_miss),
        .i_branch_miss(i_branch_miss), .correct_pc(correct_pc), .miss_count(miss_count)
    );

    typedef struct {
        string       name;
        logic [15:0] pc_if;
        logic        jv;
        logic [15:0] pc_id, jt;
        logic        pt_id;
        logic [15:0] ptg_id;
        logic        bv;
        logic [15:0] pc_ex;
        logic        bt;
        logic [15:0] btg;
        logic        pt_ex;
        logic [15:0] ptg_ex;
        logic        e_pt;
        logic [15:0] e_npc;
        logic        e_jm, e_bm;
        logic [15:0] e_cpc, e_mc;
    } vec_t;

    vec_t tbl[20];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        jump_valid_ID = 1'b0; pc_ID = 16'h0; jump_target_ID = 16'h0;
        pred_taken_ID = 1'b0; pred_target_ID = 16'h0;
        branch_valid_EX = 1'b0; pc_EX = 16'h0; branch_taken_EX = 1'b0;
        branch_target_EX = 16'h0; pred_taken_EX = 1'b0; pred_target_EX = 16'h0;
    endtask

    task automatic apply(input vec_t v);
        pc_IF = v.pc_if;
        jump_valid_ID = v.jv; pc_ID = v.pc_id; jump_target_ID = v.jt;
        pred_taken_ID = v.pt_id; pred_target_ID = v.ptg_id;
        branch_valid_EX = v.bv; pc_EX = v.pc_ex; branch_taken_EX = v.bt;
        branch_target_EX = v.btg; pred_taken_EX = v.pt_ex; pred_target_EX = v.ptg_ex;
    endtask

    task automatic lookup_check(input string name, input logic [15:0] pc,
                                input logic e_pt, input logic [15:0] e_npc);
        @(negedge clk);
        idle_inputs();
        pc_IF = pc;
        #1;
        check({name, "_pt"}, {15'h0, pred_taken}, {15'h0, e_pt});
        check({name, "_npc"}, next_pc_pred, e_npc);
        check({name, "_mc"}, miss_count, 16'h0000);
    endtask

    initial begin
        //            name         pc_if     jv    pc_id     jt        ptid  ptg_id    bv    pc_ex     bt    btg       ptex  ptg_ex    e_pt  e_npc     e_jm  e_bm  e_cpc     e_mc
        tbl[0]  = '{"rst_lookup", 16'h0010, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0011, 1'b0, 1'b0, 16'h0000, 16'd0};
        tbl[1]  = '{"jmp_alloc",  16'h0010, 1'b1, 16'h0010, 16'h0040, 1'b0, 16'h0011, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0011, 1'b1, 1'b0, 16'h0040, 16'd0};
        tbl[2]  = '{"jmp_hit",    16'h0010, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'd1};
        tbl[3]  = '{"beq_taken",  16'h0023, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0023, 1'b1, 16'h0030, 1'b0, 16'h0024, 1'b0, 16'h0024, 1'b0, 1'b1, 16'h0030, 16'd1};
        tbl[4]  = '{"beq_not",    16'h0023, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0023, 1'b0, 16'h0030, 1'b1, 16'h0030, 1'b1, 16'h0030, 1'b0, 1'b1, 16'h0024, 16'd2};
        tbl[5]  = '{"prio",       16'h0023, 1'b1, 16'h0035, 16'h0060, 1'b0, 16'h0036, 1'b1, 16'h004F, 1'b1, 16'h0070, 1'b0, 16'h0050, 1'b0, 16'h0024, 1'b0, 1'b1, 16'h0070, 16'd3};
        tbl[6]  = '{"no_jalloc",  16'h0035, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0036, 1'b0, 1'b0, 16'h0000, 16'd4};
        tbl[7]  = '{"sat1",       16'h004F, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h004F, 1'b1, 16'h0070, 1'b1, 16'h0070, 1'b1, 16'h0070, 1'b0, 1'b0, 16'h0000, 16'd4};
        tbl[8]  = '{"sat2",       16'h004F, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h004F, 1'b1, 16'h0070, 1'b1, 16'h0070, 1'b1, 16'h0070, 1'b0, 1'b0, 16'h0000, 16'd4};
        tbl[9]  = '{"sat3",       16'h004F, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h004F, 1'b1, 16'h0070, 1'b1, 16'h0070, 1'b1, 16'h0070, 1'b0, 1'b0, 16'h0000, 16'd4};
        tbl[10] = '{"sat4",       16'h004F, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h004F, 1'b1, 16'h0070, 1'b1, 16'h0070, 1'b1, 16'h0070, 1'b0, 1'b0, 16'h0000, 16'd4};
        tbl[11] = '{"sat_nt",     16'h004F, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h004F, 1'b0, 16'h0070, 1'b1, 16'h0070, 1'b1, 16'h0070, 1'b0, 1'b1, 16'h0050, 16'd4};
        tbl[12] = '{"alias_jmp",  16'h004F, 1'b1, 16'h0003, 16'h0080, 1'b0, 16'h0004, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0070, 1'b1, 1'b0, 16'h0080, 16'd5};
        tbl[13] = '{"alias_13",   16'h0013, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0014, 1'b0, 1'b0, 16'h0000, 16'd6};
        tbl[14] = '{"alias_03",   16'h0003, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0080, 1'b0, 1'b0, 16'h0000, 16'd6};
        tbl[15] = '{"same_idx",   16'h0003, 1'b1, 16'h0013, 16'h00A0, 1'b0, 16'h0014, 1'b1, 16'h0003, 1'b1, 16'h0080, 1'b1, 16'h0080, 1'b1, 16'h0080, 1'b1, 1'b0, 16'h00A0, 16'd6};
        tbl[16] = '{"drop_13",    16'h0013, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0014, 1'b0, 1'b0, 16'h0000, 16'd7};
        tbl[17] = '{"jmp_ok",     16'h0003, 1'b1, 16'h0010, 16'h0040, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0080, 1'b0, 1'b0, 16'h0000, 16'd7};
        tbl[18] = '{"jmp_tgt",    16'h0010, 1'b1, 16'h0010, 16'h0044, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b1, 1'b0, 16'h0044, 16'd7};
        tbl[19] = '{"jmp_new",    16'h0010, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0044, 1'b0, 1'b0, 16'h0000, 16'd8};

        reset = 1'b1;
        pc_IF = 16'h0;
        idle_inputs();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            apply(tbl[i]);
            exp_q.push_back(tbl[i].e_mc);
            #1;
            check({tbl[i].name, "_pt"}, {15'h0, pred_taken}, {15'h0, tbl[i].e_pt});
            check({tbl[i].name, "_npc"}, next_pc_pred, tbl[i].e_npc);
            check({tbl[i].name, "_jm"}, {15'h0, jump_miss}, {15'h0, tbl[i].e_jm});
            check({tbl[i].name, "_bm"}, {15'h0, i_branch_miss}, {15'h0, tbl[i].e_bm});
            if (tbl[i].e_jm || tbl[i].e_bm)
                check({tbl[i].name, "_cpc"}, correct_pc, tbl[i].e_cpc);
            check({tbl[i].name, "_mc"}, miss_count, exp_q.pop_front());
        end

        // Reset mid-run while a jump allocation and a branch-hit update are also presented.
        @(negedge clk);
        reset = 1'b1;
        pc_IF = 16'h0010;
        jump_valid_ID = 1'b1; pc_ID = 16'h0020; jump_target_ID = 16'h0099;
        pred_taken_ID = 1'b0; pred_target_ID = 16'h0021;
        branch_valid_EX = 1'b1; pc_EX = 16'h0003; branch_taken_EX = 1'b1;
        branch_target_EX = 16'h00B0; pred_taken_EX = 1'b1; pred_target_EX = 16'h0080;
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        pc_IF = 16'h0003;
        #1;
        check("mid_rst_pt03", {15'h0, pred_taken}, 16'h0000);
        check("mid_rst_npc03", next_pc_pred, 16'h0004);
        check("mid_rst_mc", miss_count, 16'h0000);
        check("mid_rst_jm", {15'h0, jump_miss}, 16'h0000);
        check("mid_rst_bm", {15'h0, i_branch_miss}, 16'h0000);
        lookup_check("mid_rst_20", 16'h0020, 1'b0, 16'h0021);
        lookup_check("mid_rst_10", 16'h0010, 1'b0, 16'h0011);
        lookup_check("wrap_ffff", 16'hFFFF, 1'b0, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
